mem_access_sequencer: RTL

- Multi-cycle sequencer between the core's memory-control decode outputs (mreq, mem_write, funct3) and an external req/ack data bus.
- Holds the core (stall) while an access is outstanding.
- Generates byte enables and replicated store data, and returns load data already sign- or zero-extended for register writeback.
- Reports misaligned, illegal-size and timed-out accesses as access_fault.

---
 rtl/mem_access_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between the core's memory decode and a req/ack data bus.
// Stalls the core while an access is outstanding and returns extended load data.
module mem_access_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mreq,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [31:0]      load_data_q, load_data_d;

    logic        f3_legal;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    // Request-side decode on the live decode inputs.
    always_comb begin
        f3_legal   = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = wdata;
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {addr[1], 1'b0};
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Load lane selection and extension from the latched size/offset.
    always_comb begin
        case (off_q)
            2'b00:   lane_b = bus_rdata[7:0];
            2'b01:   lane_b = bus_rdata[15:8];
            2'b10:   lane_b = bus_rdata[23:16];
            default: lane_b = bus_rdata[31:24];
        endcase
        lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        f3_d        = f3_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (mreq) begin
                    if (!f3_legal || misaligned) begin
                        state_d     = S_DONE;
                        fault_d     = 1'b1;
                        load_data_d = 32'h0;
                    end else begin
                        state_d     = S_WAIT;
                        fault_d     = 1'b0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                    end
                end
            end
            S_WAIT: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (!bus_we_q) begin
                        load_data_d = load_ext;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TO_CNT)) begin
                    bus_req_d   = 1'b0;
                    fault_d     = 1'b1;
                    load_data_d = 32'h0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
        end
    end

    assign stall        = ((state_q == S_IDLE) && mreq) || (state_q == S_WAIT);
    assign load_valid   = (state_q == S_DONE);
    assign access_fault = (state_q == S_DONE) && fault_q;
    assign load_data    = load_data_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign dbg_state    = state_q;

endmodule
